// File: rtl/dmem_lsu_bridge.sv
// dmem_lsu_bridge: load/store unit bridging the RV32I memory stage onto a
// request/grant/response data bus. Stalls the core for the duration of an
// access, extends load data per funct3 and reports timeout/misalign errors.
// Optional feature: define DMEM_MISALIGN_TRAP_EN to reject misaligned
// accesses without touching the bus.
module dmem_lsu_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        stall,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        rsp_misalign,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [2:0]       f3_q, f3_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             timeout_hit;
  logic [31:0]      load_ext;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;

  // Counter never exceeds TIMEOUT_CYCLES-1, so an equality test suffices.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef DMEM_MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  logic req_misaligned;

  // Access size from funct3 low bits: 00 byte, 01 half, anything else word.
  always_comb begin
    req_misaligned = 1'b0;
    case (req_funct3[1:0])
      2'b00:   req_misaligned = 1'b0;
      2'b01:   req_misaligned = req_addr[0];
      default: req_misaligned = (req_addr[1:0] != 2'b00);
    endcase
  end

  assign rsp_misalign = (state_q == S_RESP) & mis_q;
`else
  assign rsp_misalign = 1'b0;
`endif

  // State and transaction register update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef DMEM_MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  // Next-state logic, request latching and stall generation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef DMEM_MISALIGN_TRAP_EN
    mis_d   = mis_q;
`endif
    stall   = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall = req_valid;
        if (req_valid) begin
          addr_d  = req_addr;
          be_d    = req_be;
          wdata_d = req_wdata;
          f3_d    = req_funct3;
          rdata_d = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_ISSUE;
`ifdef DMEM_MISALIGN_TRAP_EN
          mis_d   = 1'b0;
          if (req_misaligned) begin
            state_d = S_RESP;
            err_d   = 1'b1;
            mis_d   = 1'b1;
          end
`endif
        end
      end
      S_ISSUE: begin
        stall = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (timeout_hit) begin
          state_d = S_RESP;
          err_d   = 1'b1;
        end else if (bus_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q + 1'b1;
        // A response arriving on the last allowed cycle still completes normally.
        if (bus_rvalid) begin
          state_d = S_RESP;
          rdata_d = bus_rdata;
        end else if (timeout_hit) begin
          state_d = S_RESP;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Lane selection and sign/zero extension of captured read data.
  always_comb begin
    byte_sel = rdata_q[7:0];
    case (addr_q[1:0])
      2'd0:    byte_sel = rdata_q[7:0];
      2'd1:    byte_sel = rdata_q[15:8];
      2'd2:    byte_sel = rdata_q[23:16];
      default: byte_sel = rdata_q[31:24];
    endcase
    half_sel = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    load_ext = rdata_q;
    case (f3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'h0, byte_sel};
      3'b101:  load_ext = {16'h0, half_sel};
      default: load_ext = rdata_q;
    endcase
  end

  assign rsp_err   = (state_q == S_RESP) & err_q;
  assign rsp_data  = ((state_q == S_RESP) && !err_q && (be_q == 4'h0)) ? load_ext : '0;
  assign bus_req   = (state_q == S_ISSUE);
  assign bus_addr  = bus_req ? {addr_q[31:2], 2'b00} : '0;
  assign bus_be    = bus_req ? be_q : '0;
  assign bus_wdata = bus_req ? wdata_q : '0;

endmodule

// File: tb/tb_dmem_lsu_bridge.sv
// Directed bench for dmem_lsu_bridge (TIMEOUT_CYCLES=4). Expectations switch
// on DMEM_MISALIGN_TRAP_EN to match the build of the design.
module tb_dmem_lsu_bridge;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [3:0]  req_be;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        stall;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_misalign;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;

  // Results of the last transaction run by run_txn.
  int          t_stall;
  int          t_issue;
  logic        t_ok;
  logic        t_req_seen;
  logic        t_req_at_resp;
  logic [31:0] t_data;
  logic        t_err;
  logic        t_mis;
  logic [31:0] t_addr;
  logic [3:0]  t_be;
  logic [31:0] t_wdata;

  dmem_lsu_bridge #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_be(req_be),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .stall(stall), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rsp_misalign(rsp_misalign), .bus_req(bus_req), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one core request and a simple bus responder: gnt after gnt_delay
  // ISSUE cycles, rvalid one cycle after the grant. Starts at an IDLE cycle.
  task automatic run_txn(input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3,
                         input int gnt_delay, input logic [31:0] rdata);
    logic gnt_prev;
    gnt_prev = 1'b0;
    t_stall = 0; t_issue = 0; t_ok = 1'b0; t_req_seen = 1'b0; t_req_at_resp = 1'b0;
    t_data = '0; t_err = 1'b0; t_mis = 1'b0; t_addr = '0; t_be = '0; t_wdata = '0;
    req_valid = 1'b1; req_be = be; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
    for (int k = 0; k < 40 && !t_ok; k++) begin
      if (k > 0) tick();
      bus_rvalid = gnt_prev;
      bus_rdata  = gnt_prev ? rdata : 32'h5A5A_5A5A;
      bus_gnt    = 1'b0;
      if (bus_req) begin
        t_issue++;
        t_req_seen = 1'b1;
        t_addr = bus_addr; t_be = bus_be; t_wdata = bus_wdata;
        bus_gnt = (t_issue > gnt_delay);
      end
      gnt_prev = bus_req && bus_gnt;
      #1;
      if (k > 0 && !stall) begin
        t_ok = 1'b1;
        t_data = rsp_data; t_err = rsp_err; t_mis = rsp_misalign;
        t_req_at_resp = bus_req;
      end else if (stall) begin
        t_stall++;
      end
    end
    req_valid = 1'b0; req_be = '0; req_addr = '0; req_wdata = '0; req_funct3 = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    checks++;
    if (!t_ok) begin
      errors++;
      $display("FAIL txn_complete addr=%h got no response, required response within 40 cycles", addr);
    end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_be = '0; req_addr = '0; req_wdata = '0;
    req_funct3 = '0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req got %b exp 0", bus_req); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got %h exp 0", rsp_data); end
    checks++; if (bus_addr !== 32'h0) begin errors++; $display("FAIL reset_bus_addr got %h exp 0", bus_addr); end
    tick();
  endtask

  task automatic test_loads();
    run_txn(4'h0, 32'h0000_0103, 32'h0, 3'b000, 0, 32'h80FF_1234);
    checks++; if (t_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data got %h exp ffffff80", t_data); end
    checks++; if (t_stall !== 3) begin errors++; $display("FAIL lb_stall got %0d exp 3", t_stall); end
    checks++; if (t_addr !== 32'h0000_0100) begin errors++; $display("FAIL lb_bus_addr got %h exp 00000100", t_addr); end
    checks++; if (t_be !== 4'h0) begin errors++; $display("FAIL lb_bus_be got %h exp 0", t_be); end
    checks++; if (t_err !== 1'b0) begin errors++; $display("FAIL lb_err got %b exp 0", t_err); end

    run_txn(4'h0, 32'h0000_0102, 32'h0, 3'b101, 0, 32'hBEEF_0000);
    checks++; if (t_data !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu_data got %h exp 0000beef", t_data); end

    run_txn(4'h0, 32'h0000_0102, 32'h0, 3'b001, 0, 32'h8001_0000);
    checks++; if (t_data !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_data got %h exp ffff8001", t_data); end

    run_txn(4'h0, 32'h0000_0101, 32'h0, 3'b100, 0, 32'h0000_9A00);
    checks++; if (t_data !== 32'h0000_009A) begin errors++; $display("FAIL lbu_data got %h exp 0000009a", t_data); end

    run_txn(4'h0, 32'h0000_0200, 32'h0, 3'b010, 0, 32'h1234_5678);
    checks++; if (t_data !== 32'h1234_5678) begin errors++; $display("FAIL lw_data got %h exp 12345678", t_data); end

    run_txn(4'h0, 32'h0000_0100, 32'h0, 3'b011, 0, 32'hA5A5_0F0F);
    checks++; if (t_data !== 32'hA5A5_0F0F) begin errors++; $display("FAIL undef_f3_data got %h exp a5a50f0f", t_data); end
  endtask

  task automatic test_store();
    run_txn(4'hF, 32'h0000_0200, 32'hDEAD_BEEF, 3'b010, 2, 32'hFFFF_FFFF);
    checks++; if (t_be !== 4'hF) begin errors++; $display("FAIL sw_bus_be got %h exp f", t_be); end
    checks++; if (t_addr !== 32'h0000_0200) begin errors++; $display("FAIL sw_bus_addr got %h exp 00000200", t_addr); end
    checks++; if (t_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_bus_wdata got %h exp deadbeef", t_wdata); end
    checks++; if (t_stall !== 5) begin errors++; $display("FAIL sw_stall got %0d exp 5", t_stall); end
    checks++; if (t_data !== 32'h0) begin errors++; $display("FAIL sw_rsp_data got %h exp 0", t_data); end
    checks++; if (t_err !== 1'b0) begin errors++; $display("FAIL sw_err got %b exp 0", t_err); end
  endtask

  task automatic test_timeout();
    run_txn(4'h0, 32'h0000_0300, 32'h0, 3'b010, 1000, 32'h1111_1111);
    checks++; if (t_issue !== 4) begin errors++; $display("FAIL to_issue_cycles got %0d exp 4", t_issue); end
    checks++; if (t_err !== 1'b1) begin errors++; $display("FAIL to_err got %b exp 1", t_err); end
    checks++; if (t_data !== 32'h0) begin errors++; $display("FAIL to_data got %h exp 0", t_data); end
    checks++; if (t_req_at_resp !== 1'b0) begin errors++; $display("FAIL to_bus_req got %b exp 0", t_req_at_resp); end
    checks++; if (t_stall !== 5) begin errors++; $display("FAIL to_stall got %0d exp 5", t_stall); end
  endtask

  task automatic test_misalign();
    run_txn(4'h0, 32'h0000_0201, 32'h0, 3'b010, 0, 32'hCAFE_F00D);
`ifdef DMEM_MISALIGN_TRAP_EN
    checks++; if (t_req_seen !== 1'b0) begin errors++; $display("FAIL mis_lw_bus_req got %b exp 0", t_req_seen); end
    checks++; if (t_err !== 1'b1) begin errors++; $display("FAIL mis_lw_err got %b exp 1", t_err); end
    checks++; if (t_mis !== 1'b1) begin errors++; $display("FAIL mis_lw_misalign got %b exp 1", t_mis); end
    checks++; if (t_data !== 32'h0) begin errors++; $display("FAIL mis_lw_data got %h exp 0", t_data); end
    checks++; if (t_stall !== 1) begin errors++; $display("FAIL mis_lw_stall got %0d exp 1", t_stall); end
    run_txn(4'h3, 32'h0000_0105, 32'h0000_4444, 3'b001, 0, 32'h0);
    checks++; if (t_mis !== 1'b1) begin errors++; $display("FAIL mis_sh_misalign got %b exp 1", t_mis); end
    checks++; if (t_req_seen !== 1'b0) begin errors++; $display("FAIL mis_sh_bus_req got %b exp 0", t_req_seen); end
`else
    checks++; if (t_addr !== 32'h0000_0200) begin errors++; $display("FAIL mis_lw_bus_addr got %h exp 00000200", t_addr); end
    checks++; if (t_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL mis_lw_data got %h exp cafef00d", t_data); end
    checks++; if (t_err !== 1'b0) begin errors++; $display("FAIL mis_lw_err got %b exp 0", t_err); end
    checks++; if (t_mis !== 1'b0) begin errors++; $display("FAIL mis_lw_misalign got %b exp 0", t_mis); end
    run_txn(4'h0, 32'h0000_0103, 32'h0, 3'b001, 0, 32'h8123_0000);
    checks++; if (t_data !== 32'hFFFF_8123) begin errors++; $display("FAIL mis_lh_data got %h exp ffff8123", t_data); end
`endif
  endtask

  task automatic test_back_to_back();
    run_txn(4'h0, 32'h0000_0400, 32'h0, 3'b010, 0, 32'h0BAD_F00D);
    checks++; if (t_data !== 32'h0BAD_F00D) begin errors++; $display("FAIL b2b_first got %h exp 0badf00d", t_data); end
    run_txn(4'h0, 32'h0000_0402, 32'h0, 3'b000, 0, 32'h007F_0000);
    checks++; if (t_data !== 32'h0000_007F) begin errors++; $display("FAIL b2b_second got %h exp 0000007f", t_data); end
    checks++; if (t_stall !== 3) begin errors++; $display("FAIL b2b_stall got %0d exp 3", t_stall); end
  endtask

  task automatic test_reset_mid();
    // Reset while in ISSUE drops bus_req on the next edge.
    req_valid = 1'b1; req_be = 4'h0; req_addr = 32'h0000_0500; req_funct3 = 3'b010;
    tick();
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rst_issue_req got %b exp 1", bus_req); end
    reset = 1'b1; req_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rst_issue_drop got %b exp 0", bus_req); end
    tick();
    // Reset while in WAIT, then a stray rvalid.
    req_valid = 1'b1; req_be = 4'h0; req_addr = 32'h0000_0600; req_funct3 = 3'b010;
    tick();
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    #1;
    checks++; if (stall !== 1'b1 || bus_req !== 1'b0) begin errors++; $display("FAIL rst_wait_state got stall=%b req=%b exp stall=1 req=0", stall, bus_req); end
    reset = 1'b1; req_valid = 1'b0;
    tick();
    reset = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h7777_7777;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_wait_stall got %b exp 0", stall); end
    tick();
    bus_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (stall !== 1'b0 || rsp_err !== 1'b0 || rsp_data !== 32'h0 || bus_req !== 1'b0) begin
        errors++;
        $display("FAIL rst_stray_rvalid got stall=%b err=%b data=%h req=%b exp all 0", stall, rsp_err, rsp_data, bus_req);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_store();
    test_timeout();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
